// File: rtl/commit_store_buffer.sv
// Post-commit store buffer: queues committed store register indices, resolves one per cycle
// through the RF, and drains {addr, data} to L1D. Optional perf counters: COMMIT_STORE_BUF_PERF_EN.
module commit_store_buffer #(
  parameter int unsigned Q_WIDTH   = 4,   // uop_pkg::INSTR_Q_WIDTH
  parameter int unsigned SB_DEPTH  = 8,
  parameter int unsigned ADDR_BITS = 64,
  parameter int unsigned WORD_SIZE = 64,
  parameter int unsigned REG_BITS  = 5    // $clog2(reg_pkg::NUM_ARCH_REGS)
) (
  input  logic                               clk_in,
  input  logic                               rst_N_in,
  input  logic [Q_WIDTH-1:0]                 valid_str_in,
  input  logic [Q_WIDTH-1:0][REG_BITS-1:0]   str_addr_reg_in,
  input  logic [Q_WIDTH-1:0][REG_BITS-1:0]   str_addr_reg_off_in,
  input  logic [Q_WIDTH-1:0][REG_BITS-1:0]   str_val_reg_in,
  output logic                               str_ready_out,
  output logic [REG_BITS-1:0]                rf_base_idx_out,
  output logic [REG_BITS-1:0]                rf_off_idx_out,
  output logic [REG_BITS-1:0]                rf_val_idx_out,
  input  logic [WORD_SIZE-1:0]               rf_base_data_in,
  input  logic [WORD_SIZE-1:0]               rf_off_data_in,
  input  logic [WORD_SIZE-1:0]               rf_val_data_in,
  output logic                               mem_valid_out,
  input  logic                               mem_ready_in,
  output logic [ADDR_BITS-1:0]               mem_addr_out,
  output logic [WORD_SIZE-1:0]               mem_data_out,
  output logic                               sb_empty_out,
`ifdef COMMIT_STORE_BUF_PERF_EN
  output logic                               overflow_err_out,
  output logic [31:0]                        perf_stores_out,
  output logic [31:0]                        perf_stall_out
`else
  output logic                               overflow_err_out
`endif
);

  localparam int unsigned PTR_W = $clog2(SB_DEPTH);
  localparam int unsigned CNT_W = $clog2(SB_DEPTH + 1);

  typedef struct packed {
    logic [REG_BITS-1:0] base;
    logic [REG_BITS-1:0] off;
    logic [REG_BITS-1:0] val;
  } sb_entry_t;

  typedef enum logic {OUT_EMPTY, OUT_HELD} out_state_e;

  logic                            rst_meta_q, rst_sync_q;
  sb_entry_t                       mem_q [SB_DEPTH];
  logic [PTR_W-1:0]                head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]                count_q, count_d, push_cnt;
  logic [Q_WIDTH-1:0][PTR_W-1:0]   lane_slot;
  out_state_e                      state_q, state_d;
  logic [ADDR_BITS-1:0]            addr_q, addr_d;
  logic [WORD_SIZE-1:0]            data_q, data_d;
  logic                            err_q;
  logic                            push_en, pop, violation;
  sb_entry_t                       head_ent;

  // Reset asserts asynchronously, releases on a clock edge
  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_sync_q <= rst_meta_q;
    end
  end

  assign str_ready_out = (32'(SB_DEPTH) - 32'(count_q)) >= 32'(Q_WIDTH);
  assign push_en       = str_ready_out;
  assign violation     = !str_ready_out && (|valid_str_in);
  assign pop           = (count_q != '0) && ((state_q == OUT_EMPTY) || mem_ready_in);
  assign head_ent      = mem_q[head_q];

  // Compaction: each valid lane lands at tail plus the number of valid lanes below it
  always_comb begin
    push_cnt  = '0;
    lane_slot = '0;
    for (int unsigned l = 0; l < Q_WIDTH; l++) begin
      lane_slot[l] = tail_q + PTR_W'(push_cnt);
      if (valid_str_in[l]) push_cnt = push_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    for (int unsigned l = 0; l < Q_WIDTH; l++) begin
      if (push_en && valid_str_in[l]) begin
        mem_q[lane_slot[l]] <= '{base: str_addr_reg_in[l],
                                 off:  str_addr_reg_off_in[l],
                                 val:  str_val_reg_in[l]};
      end
    end
  end

  always_comb begin
    head_d  = head_q + PTR_W'(pop);
    tail_d  = tail_q + (push_en ? PTR_W'(push_cnt) : '0);
    count_d = count_q + (push_en ? push_cnt : '0) - CNT_W'(pop);
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (pop) begin
      state_d = OUT_HELD;
      addr_d  = ADDR_BITS'(rf_base_data_in + rf_off_data_in);
      data_d  = rf_val_data_in;
    end else if ((state_q == OUT_HELD) && mem_ready_in) begin
      state_d = OUT_EMPTY;
    end
  end

  always_ff @(posedge clk_in or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      state_q <= OUT_EMPTY;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_q | violation;
    end
  end

  assign rf_base_idx_out  = (count_q != '0) ? head_ent.base : '0;
  assign rf_off_idx_out   = (count_q != '0) ? head_ent.off  : '0;
  assign rf_val_idx_out   = (count_q != '0) ? head_ent.val  : '0;
  assign mem_valid_out    = (state_q == OUT_HELD);
  assign mem_addr_out     = addr_q;
  assign mem_data_out     = data_q;
  assign sb_empty_out     = (count_q == '0) && (state_q == OUT_EMPTY);
  assign overflow_err_out = err_q;

`ifdef COMMIT_STORE_BUF_PERF_EN
  logic [31:0] perf_stores_q, perf_stall_q;

  // Saturating event counters
  always_ff @(posedge clk_in or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      perf_stores_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      if (mem_valid_out && mem_ready_in && (perf_stores_q != '1)) perf_stores_q <= perf_stores_q + 32'd1;
      if (!str_ready_out && (perf_stall_q != '1)) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_stores_out = perf_stores_q;
  assign perf_stall_out  = perf_stall_q;
`endif

endmodule

// File: tb/tb_commit_store_buffer.sv
// Bench for commit_store_buffer: directed and random stores checked against a queue-based model.
module tb_commit_store_buffer;
  localparam int unsigned QW = 4;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned RB = 5;

  logic                     clk, rst_N_in;
  logic [QW-1:0]            valid_str_in;
  logic [QW-1:0][RB-1:0]    str_addr_reg_in, str_addr_reg_off_in, str_val_reg_in;
  logic                     str_ready_out;
  logic [RB-1:0]            rf_base_idx_out, rf_off_idx_out, rf_val_idx_out;
  logic [63:0]              rf_base_data_in, rf_off_data_in, rf_val_data_in;
  logic                     mem_valid_out, mem_ready_in;
  logic [63:0]              mem_addr_out, mem_data_out;
  logic                     sb_empty_out, overflow_err_out;

  logic [63:0] rf [32];
  assign rf_base_data_in = rf[rf_base_idx_out];
  assign rf_off_data_in  = rf[rf_off_idx_out];
  assign rf_val_data_in  = rf[rf_val_idx_out];

  commit_store_buffer #(.Q_WIDTH(QW), .SB_DEPTH(DEPTH), .ADDR_BITS(64), .WORD_SIZE(64), .REG_BITS(RB)) dut (
    .clk_in(clk), .rst_N_in(rst_N_in), .valid_str_in(valid_str_in),
    .str_addr_reg_in(str_addr_reg_in), .str_addr_reg_off_in(str_addr_reg_off_in),
    .str_val_reg_in(str_val_reg_in), .str_ready_out(str_ready_out),
    .rf_base_idx_out(rf_base_idx_out), .rf_off_idx_out(rf_off_idx_out), .rf_val_idx_out(rf_val_idx_out),
    .rf_base_data_in(rf_base_data_in), .rf_off_data_in(rf_off_data_in), .rf_val_data_in(rf_val_data_in),
    .mem_valid_out(mem_valid_out), .mem_ready_in(mem_ready_in), .mem_addr_out(mem_addr_out),
    .mem_data_out(mem_data_out), .sb_empty_out(sb_empty_out), .overflow_err_out(overflow_err_out));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: pending index entries, the held request, the sticky error flag
  typedef struct { logic [RB-1:0] b, o, v; } ent_t;
  ent_t        idxq [$];
  logic        m_held, m_err;
  logic [63:0] m_addr, m_data;
  int          n_checks = 0, n_pass = 0, n_done = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  task automatic model_reset();
    idxq.delete();
    m_held = 1'b0; m_err = 1'b0; m_addr = '0; m_data = '0;
  endtask

  // One cycle: drive inputs, check outputs against model, advance model across the edge
  task automatic step(input logic [QW-1:0] vld, input logic rdy);
    ent_t e;
    bit   rdy_m, do_pop;
    valid_str_in = vld;
    mem_ready_in = rdy;
    #1;
    chk("mem_valid", 64'(mem_valid_out), 64'(m_held));
    if (m_held) begin
      chk("mem_addr", mem_addr_out, m_addr);
      chk("mem_data", mem_data_out, m_data);
    end
    rdy_m = (DEPTH - idxq.size()) >= QW;
    chk("str_ready", 64'(str_ready_out), 64'(rdy_m));
    chk("sb_empty", 64'(sb_empty_out), 64'(idxq.size() == 0 && !m_held));
    chk("overflow", 64'(overflow_err_out), 64'(m_err));
    chk("rf_base_idx", 64'(rf_base_idx_out), (idxq.size() != 0) ? 64'(idxq[0].b) : 64'd0);
    chk("rf_val_idx", 64'(rf_val_idx_out), (idxq.size() != 0) ? 64'(idxq[0].v) : 64'd0);
    do_pop = (idxq.size() != 0) && (!m_held || rdy);
    if (m_held && rdy) n_done++;
    if (do_pop) begin
      e = idxq.pop_front();
      m_addr = rf[e.b] + rf[e.o];
      m_data = rf[e.v];
      m_held = 1'b1;
    end else if (m_held && rdy) begin
      m_held = 1'b0;
    end
    if (rdy_m) begin
      for (int l = 0; l < QW; l++)
        if (vld[l]) idxq.push_back('{b: str_addr_reg_in[l], o: str_addr_reg_off_in[l], v: str_val_reg_in[l]});
    end else if (vld != '0) begin
      m_err = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic rand_lanes();
    for (int l = 0; l < QW; l++) begin
      str_addr_reg_in[l]     = RB'($urandom_range(0, 31));
      str_addr_reg_off_in[l] = RB'($urandom_range(0, 31));
      str_val_reg_in[l]      = RB'($urandom_range(0, 31));
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (idxq.size() != 0 || m_held); i++) step('0, 1'b1);
    chk("drained_empty", 64'(sb_empty_out), 64'd1);
  endtask

  initial begin
    logic [63:0] exp_a0, exp_a3;
    for (int i = 0; i < 32; i++) rf[i] = {$urandom(), $urandom()};
    valid_str_in = '0; mem_ready_in = 1'b0;
    str_addr_reg_in = '0; str_addr_reg_off_in = '0; str_val_reg_in = '0;
    model_reset();
    rst_N_in = 1'b1;
    #2 rst_N_in = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_mem_valid", 64'(mem_valid_out), 64'd0);
    chk("rst_mem_addr", mem_addr_out, 64'd0);
    chk("rst_mem_data", mem_data_out, 64'd0);
    chk("rst_overflow", 64'(overflow_err_out), 64'd0);
    chk("rst_str_ready", 64'(str_ready_out), 64'd1);
    chk("rst_sb_empty", 64'(sb_empty_out), 64'd1);
    chk("rst_rf_idx", 64'(rf_off_idx_out), 64'd0);
    @(negedge clk);
    rst_N_in = 1'b1;
    repeat (3) step('0, 1'b1);

    // Single store on lane 2
    rf[1] = 64'h1000; rf[2] = 64'h20; rf[3] = 64'hDEAD;
    str_addr_reg_in[2] = 5'd1; str_addr_reg_off_in[2] = 5'd2; str_val_reg_in[2] = 5'd3;
    step(4'b0100, 1'b1);
    step('0, 1'b1);
    chk("t1_valid", 64'(mem_valid_out), 64'd1);
    chk("t1_addr", mem_addr_out, 64'h1020);
    chk("t1_data", mem_data_out, 64'hDEAD);
    step('0, 1'b1);
    chk("t1_empty_again", 64'(sb_empty_out), 64'd1);

    // Lanes 0 and 3: lane 0 drains first, then lane 3 on the next cycle
    for (int i = 7; i <= 12; i++) rf[i] = {$urandom(), $urandom()};
    str_addr_reg_in[0] = 5'd7;  str_addr_reg_off_in[0] = 5'd8;  str_val_reg_in[0] = 5'd9;
    str_addr_reg_in[3] = 5'd10; str_addr_reg_off_in[3] = 5'd11; str_val_reg_in[3] = 5'd12;
    exp_a0 = rf[7] + rf[8];
    exp_a3 = rf[10] + rf[11];
    step(4'b1001, 1'b1);
    step('0, 1'b1);
    chk("t2_first_addr", mem_addr_out, exp_a0);
    step('0, 1'b1);
    chk("t2_second_addr", mem_addr_out, exp_a3);
    chk("t2_second_data", mem_data_out, rf[12]);
    drain();

    // Address wrap mod 2^64
    rf[4] = 64'hFFFF_FFFF_FFFF_FFF8; rf[5] = 64'h10; rf[6] = 64'h1234_5678;
    str_addr_reg_in[0] = 5'd4; str_addr_reg_off_in[0] = 5'd5; str_val_reg_in[0] = 5'd6;
    step(4'b0001, 1'b1);
    step('0, 1'b1);
    chk("wrap_addr", mem_addr_out, 64'h8);
    chk("wrap_data", mem_data_out, 64'h1234_5678);
    drain();

    // Backpressure: fill with ready low, then violate, then drain in order
    rand_lanes(); step(4'hF, 1'b0);
    rand_lanes(); step(4'hF, 1'b0);
    chk("bp_ready_drop", 64'(str_ready_out), 64'd0);
    rand_lanes(); step(4'b0011, 1'b0);
    chk("bp_overflow_set", 64'(overflow_err_out), 64'd1);
    repeat (3) step('0, 1'b0);
    drain();
    chk("bp_overflow_sticky", 64'(overflow_err_out), 64'd1);

    // Reset while holding a request with 3 more queued
    rand_lanes(); step(4'hF, 1'b0);
    step('0, 1'b0);
    chk("rst_mid_held", 64'(mem_valid_out), 64'd1);
    rst_N_in = 1'b0;
    #1;
    chk("rst_mid_valid_drop", 64'(mem_valid_out), 64'd0);
    chk("rst_mid_addr", mem_addr_out, 64'd0);
    chk("rst_mid_empty", 64'(sb_empty_out), 64'd1);
    chk("rst_mid_err_clr", 64'(overflow_err_out), 64'd0);
    model_reset();
    @(negedge clk);
    rst_N_in = 1'b1;
    repeat (4) step('0, 1'b1);

    // Random traffic, enough stores to wrap the pointers several times
    n_done = 0;
    for (int c = 0; c < 80; c++) begin
      rand_lanes();
      if ($urandom_range(0, 7) == 0) rf[$urandom_range(0, 31)] = {$urandom(), $urandom()};
      step(($urandom_range(0, 1) == 0) ? '0 : QW'($urandom_range(0, 15)), $urandom_range(0, 3) != 0);
    end
    drain();
    chk("rand_many_stores", 64'(n_done > 16), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/commit_store_buffer.md
# commit_store_buffer

Post-commit store buffer sitting directly downstream of the reorder buffer's commit stage. Accepts up to Q_WIDTH committed stores per cycle as architectural register indices (address base, address offset, value). Resolves them in program order, one per cycle, by reading the architectural register file and computing base+offset. Drains the resulting {address, data} pairs to the L1D write port over a valid/ready handshake. Committed stores are architectural state, so no flush input exists; only reset discards entries.

## Interface
Parameters:
- Q_WIDTH, uop_pkg::INSTR_Q_WIDTH, commit lanes per cycle
- SB_DEPTH, 8, index-queue entries; power of two, >= Q_WIDTH
- ADDR_BITS, 64, store address width
- WORD_SIZE, 64, store data width and register width
- REG_BITS, $clog2(reg_pkg::NUM_ARCH_REGS), arch register index width

Ports:
- clk_in  in  1  clock
- rst_N_in  in  1  reset; one clock, reset is asynchronous and active-low
- valid_str_in  in  Q_WIDTH  per-lane committed-store valid
- str_addr_reg_in  in  Q_WIDTH x REG_BITS  base-address arch reg per lane
- str_addr_reg_off_in  in  Q_WIDTH x REG_BITS  offset arch reg per lane
- str_val_reg_in  in  Q_WIDTH x REG_BITS  store-value arch reg per lane
- str_ready_out  out  1  buffer can take a full Q_WIDTH group this cycle
- rf_base_idx_out / rf_off_idx_out / rf_val_idx_out  out  REG_BITS each  RF read addresses
- rf_base_data_in / rf_off_data_in / rf_val_data_in  in  WORD_SIZE each  RF read data, combinational same cycle
- mem_valid_out  out  1  store request valid to L1D
- mem_ready_in  in  1  L1D accepts request
- mem_addr_out  out  ADDR_BITS  store address
- mem_data_out  out  WORD_SIZE  store data
- sb_empty_out  out  1  index queue empty and no request pending
- overflow_err_out  out  1  sticky protocol-violation flag

## Operation
- Index queue: circular, SB_DEPTH entries of {base, off, val} indices; head/tail pointers $clog2(SB_DEPTH) bits, wrap naturally; count $clog2(SB_DEPTH+1) bits.
- str_ready_out = (SB_DEPTH - count) >= Q_WIDTH, from registered count only. It does not depend on the same-cycle pop.
- Enqueue: when str_ready_out is 1, valid lanes are written at tail in ascending lane order, skipping invalid lanes (compaction). tail advances by popcount(valid_str_in).
- Violation: any valid lane while str_ready_out is 0 drops the whole group, enqueues nothing, and sets overflow_err_out, which stays set until reset.
- Output register states:
  - EMPTY: mem_valid_out=0.
  - HELD: mem_valid_out=1. Address/data stay stable until mem_ready_in=1.
- Resolve condition: queue non-empty AND (EMPTY OR (HELD AND mem_ready_in)).
- When the resolve condition holds:
  - rf_*_idx_out are driven from the head entry.
  - The output register loads {rf_base_data_in + rf_off_data_in (truncated to ADDR_BITS, mod 2^ADDR_BITS), rf_val_data_in}.
  - Head pops; state becomes HELD.
- HELD with mem_ready_in=1 and an empty queue goes to EMPTY.
- rf_*_idx_out show the head entry whenever the queue is non-empty, and 0 otherwise.
- count_next = count + pushes - pop. Push and pop in the same cycle are legal, including at count = SB_DEPTH - Q_WIDTH.
- sb_empty_out = (count == 0) AND EMPTY.

## Timing
- Reset (async assert, sync deassert internally):
  - head/tail/count = 0, output register EMPTY.
  - mem_valid_out=0, mem_addr_out=0, mem_data_out=0, overflow_err_out=0.
  - str_ready_out=1, sb_empty_out=1, rf_*_idx_out=0.
- Latency:
  - Group sampled at edge N → head visible in cycle N+1 (no enqueue-to-resolve bypass).
  - RF is read in cycle N+1 → mem_valid_out rises in cycle N+2.
- Throughput: one store per cycle with mem_ready_in held high.
- Reset asserted mid-operation discards all queued and held stores immediately; no request is completed.
- mem_valid_out is never deasserted without a handshake.

## Configuration
- COMMIT_STORE_BUF_PERF_EN defined: adds two outputs.
  - perf_stores_out (32-bit): increments on each mem_valid_out & mem_ready_in.
  - perf_stall_out (32-bit): increments each cycle str_ready_out=0.
  - Both saturate at 2^32-1 and reset to 0.
- Undefined: neither port nor any counter logic exists; all other behaviour is identical.

## Test plan
- Reset then one store on lane 2 (base r1=0x1000, off r2=0x20, val r3=0xDEAD), mem_ready_in=1 → single request addr 0x1020, data 0xDEAD in cycle N+2; sb_empty_out returns to 1 next cycle.
- Lanes {0,3} valid in the same cycle → lane 0 store drains before lane 3, on consecutive cycles.
- mem_ready_in=0 while 8 stores enqueue (SB_DEPTH=8, Q_WIDTH=4):
  - str_ready_out drops when count > 4.
  - mem_addr_out/mem_data_out stay stable while held.
  - After ready rises, all stores drain in order, one per cycle.
- Valid lane while str_ready_out=0 → no enqueue, overflow_err_out=1 and sticky; queued stores are unaffected.
- base=0xFFFF_FFFF_FFFF_FFF8, off=0x10 → mem_addr_out=0x8 (wrap); pointer wrap is exercised with more than 16 total stores, and order is preserved.
- rst_N_in pulsed low while HELD with 3 queued → mem_valid_out drops asynchronously; after release sb_empty_out=1 and no stale request appears.
